ram_port_arbiter: RTL and testbench

// - Shares one single-port RAM instance (ram_output/ram_weights style) between one write requester and one read requester.
// - Issues at most one RAM access per cycle, with round-robin arbitration.
// - Tracks read latency and returns read data on a valid/ready stream through an internal credit-checked output FIFO.
// - Sits between the RAM instance and the datapath blocks that fill and drain it.

---
 rtl/ram_port_arbiter.sv | 100 ++++++++++
 tb/tb_ram_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a writer and a reader.
// Read data returns through a credit-checked FIFO so pushes can never overflow it.
module ram_port_arbiter #(
  parameter  int DEPTH   = 64,
  parameter  int WIDTH   = 32,
  parameter  int LATENCY = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_wr_valid,
  output logic             s_wr_ready,
  input  logic [AW-1:0]    s_wr_addr,
  input  logic [WIDTH-1:0] s_wr_data,
  input  logic             s_rd_valid,
  output logic             s_rd_ready,
  input  logic [AW-1:0]    s_rd_addr,
  output logic             m_rd_valid,
  input  logic             m_rd_ready,
  output logic [WIDTH-1:0] m_rd_data,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam int OUT_DEPTH = LATENCY + 2;
  localparam int CW        = $clog2(OUT_DEPTH + 1);
  localparam int CW1       = CW + 1;

  logic               last_rd_q;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic [CW-1:0]      count_q, count_d, wr_idx;
  logic [WIDTH-1:0]   mem_q [OUT_DEPTH];
  logic [WIDTH-1:0]   mem_d [OUT_DEPTH];
  logic [CW1-1:0]     inflight, credit_used;
  logic               wr_ok, rd_ok, wr_gnt, rd_gnt, push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + CW1'(tag_q[i]);
  end

  // A read is only granted if its data is guaranteed a FIFO slot on arrival.
  assign credit_used = inflight + CW1'(count_q);
  assign rd_ok  = !rst && s_rd_valid && (credit_used < CW1'(OUT_DEPTH));
  assign wr_ok  = !rst && s_wr_valid;
  assign wr_gnt = wr_ok && (!rd_ok || last_rd_q);
  assign rd_gnt = rd_ok && !wr_gnt;

  assign s_wr_ready = wr_gnt;
  assign s_rd_ready = rd_gnt;
  assign ram_ena    = !rst;
  assign ram_wea    = wr_gnt;
  assign ram_addr   = wr_gnt ? s_wr_addr : s_rd_addr;
  assign ram_din    = s_wr_data;

  assign push       = tag_q[LATENCY-1];
  assign m_rd_valid = (count_q != '0);
  assign m_rd_data  = mem_q[0];
  assign pop        = m_rd_valid && m_rd_ready;
  assign wr_idx     = count_q - CW'(pop);
  assign count_d    = count_q + CW'(push) - CW'(pop);

  always_comb begin
    tag_d    = '0;
    tag_d[0] = rd_gnt;
    for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  // Head-at-slot-0 FIFO: only valid entries shift, so the head holds once drained.
  always_comb begin
    for (int i = 0; i < OUT_DEPTH; i++) mem_d[i] = mem_q[i];
    if (pop)
      for (int i = 0; i < OUT_DEPTH - 1; i++)
        if (CW'(i + 1) < count_q) mem_d[i] = mem_q[i+1];
    if (push)
      for (int i = 0; i < OUT_DEPTH; i++)
        if (CW'(i) == wr_idx) mem_d[i] = ram_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rd_q <= 1'b1;
      tag_q     <= '0;
      count_q   <= '0;
      mem_q     <= '{default: '0};
    end else begin
      if (wr_gnt || rd_gnt) last_rd_q <= rd_gnt;
      tag_q   <= tag_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  always @(posedge clk)
    if (!rst) assert (!(push && !pop && count_q == CW'(OUT_DEPTH)));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three instances (LATENCY 1..3), each with a RAM model,
// exercised one at a time against a scoreboard of expected read data.
module tb_ram_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 6;
  localparam int W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         rst, s_wr_valid, s_wr_ready, s_rd_valid, s_rd_ready;
  logic [N-1:0]         m_rd_valid, m_rd_ready, ram_ena, ram_wea;
  logic [N-1:0][AW-1:0] s_wr_addr, s_rd_addr, ram_addr;
  logic [N-1:0][W-1:0]  s_wr_data, m_rd_data, ram_din, ram_dout;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = g + 1;
    logic [W-1:0] rmem [64] = '{default: '0};
    logic [W-1:0] pipe [L]  = '{default: '0};
    always @(posedge clk)
      if (ram_ena[g]) begin
        if (ram_wea[g]) rmem[ram_addr[g]] <= ram_din[g];
        pipe[0] <= rmem[ram_addr[g]];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
    assign ram_dout[g] = pipe[L-1];

    ram_port_arbiter #(.DEPTH(64), .WIDTH(W), .LATENCY(L)) u_dut (
      .clk(clk), .rst(rst[g]),
      .s_wr_valid(s_wr_valid[g]), .s_wr_ready(s_wr_ready[g]),
      .s_wr_addr(s_wr_addr[g]), .s_wr_data(s_wr_data[g]),
      .s_rd_valid(s_rd_valid[g]), .s_rd_ready(s_rd_ready[g]), .s_rd_addr(s_rd_addr[g]),
      .m_rd_valid(m_rd_valid[g]), .m_rd_ready(m_rd_ready[g]), .m_rd_data(m_rd_data[g]),
      .ram_ena(ram_ena[g]), .ram_wea(ram_wea[g]), .ram_addr(ram_addr[g]),
      .ram_din(ram_din[g]), .ram_dout(ram_dout[g])
    );
  end

  int n_tests = 0, n_fail = 0, cyc_n = 0;
  int first_gnt, first_out, n_out;
  bit wr_hs, rd_hs;
  logic [W-1:0] sb_mem [N][64] = '{default: '{default: '0}};
  logic [W-1:0] exp_q[$];
  int ocyc_q[$];
  int gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic monitor(input int k);
    wr_hs = s_wr_valid[k] && s_wr_ready[k];
    rd_hs = s_rd_valid[k] && s_rd_ready[k];
    if (s_wr_ready[k] || s_rd_ready[k])
      chk("one_grant", 32'(s_wr_ready[k] & s_rd_ready[k]), 32'd0);
    if (wr_hs) begin
      sb_mem[k][s_wr_addr[k]] = s_wr_data[k];
      gnt_log.push_back(0);
    end
    if (rd_hs) begin
      exp_q.push_back(sb_mem[k][s_rd_addr[k]]);
      gnt_log.push_back(1);
      if (first_gnt < 0) first_gnt = cyc_n;
    end
    if (m_rd_valid[k] && m_rd_ready[k]) begin
      n_out++;
      ocyc_q.push_back(cyc_n);
      if (first_out < 0) first_out = cyc_n;
      if (exp_q.size() == 0) chk("spurious_out", 32'(m_rd_valid[k]), 32'd0);
      else chk("rd_data", m_rd_data[k], exp_q.pop_front());
    end
  endtask

  task automatic tick(input int k);
    @(negedge clk);
    monitor(k);
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic clear_stats();
    first_gnt = -1; first_out = -1; n_out = 0;
    ocyc_q.delete(); gnt_log.delete();
  endtask

  task automatic drain(input int k);
    m_rd_ready[k] = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick(k);
    chk("drain_empty", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) tick(k);
  endtask

  task automatic reset_inst(input int k);
    rst[k] = 1'b1;
    s_wr_valid[k] = 1'b1; s_rd_valid[k] = 1'b1; m_rd_ready[k] = 1'b0;
    #1;
    chk("rst_wr_ready", 32'(s_wr_ready[k]), 0);
    chk("rst_rd_ready", 32'(s_rd_ready[k]), 0);
    chk("rst_m_valid",  32'(m_rd_valid[k]), 0);
    chk("rst_m_data",   m_rd_data[k], 0);
    chk("rst_ram_ena",  32'(ram_ena[k]), 0);
    chk("rst_ram_wea",  32'(ram_wea[k]), 0);
    tick(k); tick(k);
    s_wr_valid[k] = 1'b0; s_rd_valid[k] = 1'b0;
    rst[k] = 1'b0;
    tick(k);
  endtask

  task automatic test1(input int k);
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      s_wr_valid[k] = 1'b1; s_wr_addr[k] = AW'(i); s_wr_data[k] = 32'hA0 + 32'(i);
      tick(k);
      chk("t1_wr_acc", 32'(wr_hs), 1);
    end
    s_wr_valid[k] = 1'b0;
    m_rd_ready[k] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_rd_valid[k] = 1'b1; s_rd_addr[k] = AW'(i);
      tick(k);
      chk("t1_rd_acc", 32'(rd_hs), 1);
    end
    s_rd_valid[k] = 1'b0;
    drain(k);
    chk("t1_latency", first_out - first_gnt, k + 2);
    chk("t1_nout", n_out, 4);
  endtask

  task automatic test2(input int k);
    int wa[4] = '{5, 6, 7, 8};
    int wd[4] = '{'h55, 'h66, 'h77, 'h88};
    int ra[4] = '{5, 6, 0, 7};
    int wi = 0, ri = 0;
    clear_stats();
    m_rd_ready[k] = 1'b1;
    for (int t = 0; t < 20 && (wi < 4 || ri < 4); t++) begin
      s_wr_valid[k] = (wi < 4);
      if (wi < 4) begin s_wr_addr[k] = AW'(wa[wi]); s_wr_data[k] = wd[wi]; end
      s_rd_valid[k] = (ri < 4);
      if (ri < 4) s_rd_addr[k] = AW'(ra[ri]);
      tick(k);
      if (wr_hs) wi++;
      if (rd_hs) ri++;
    end
    s_wr_valid[k] = 1'b0; s_rd_valid[k] = 1'b0;
    chk("t2_ngrants", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("t2_alternate", gnt_log[i], i % 2);
    drain(k);
    chk("t2_nout", n_out, 4);
  endtask

  task automatic test3(input int k);
    int acc = 0;
    logic [W-1:0] held = '0;
    clear_stats();
    m_rd_ready[k] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      s_rd_valid[k] = 1'b1; s_rd_addr[k] = AW'(acc % 4);
      tick(k);
      if (rd_hs) acc++;
      if (t == 7) held = m_rd_data[k];
    end
    chk("t3_stall_ready", 32'(s_rd_ready[k]), 0);
    chk("t3_accepted", acc, k + 3);
    chk("t3_hold_data", m_rd_data[k], held);
    s_rd_valid[k] = 1'b0;
    drain(k);
    chk("t3_nout", n_out, k + 3);
  endtask

  task automatic test4(input int k);
    int gc = 0;
    for (int i = 0; i < 16; i++) begin
      s_wr_valid[k] = 1'b1; s_wr_addr[k] = AW'(16 + i); s_wr_data[k] = $urandom;
      tick(k);
    end
    s_wr_valid[k] = 1'b0;
    clear_stats();
    m_rd_ready[k] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_rd_valid[k] = 1'b1; s_rd_addr[k] = AW'(16 + i);
      tick(k);
      if (rd_hs) gc++;
    end
    s_rd_valid[k] = 1'b0;
    chk("t4_grants", gc, 16);
    drain(k);
    chk("t4_nout", n_out, 16);
    chk("t4_out_span", (ocyc_q.size() == 16) ? ocyc_q[15] - ocyc_q[0] : -1, 15);
  endtask

  task automatic test5(input int k);
    clear_stats();
    m_rd_ready[k] = 1'b0;
    for (int t = 0; t < 20; t++) begin
      s_rd_valid[k] = 1'b1; s_rd_addr[k] = AW'(t % 4);
      tick(k);
      if (m_rd_valid[k]) break;
    end
    chk("t5_fifo_loaded", 32'(m_rd_valid[k]), 1);
    s_rd_valid[k] = 1'b0;
    rst[k] = 1'b1;
    #1;
    chk("t5_async_valid", 32'(m_rd_valid[k]), 0);
    chk("t5_rst_ena", 32'(ram_ena[k]), 0);
    exp_q.delete();
    tick(k); tick(k);
    rst[k] = 1'b0;
    clear_stats();
    m_rd_ready[k] = 1'b1;
    for (int i = 0; i < 8; i++) tick(k);
    chk("t5_no_stale", n_out, 0);
    s_rd_valid[k] = 1'b1; s_rd_addr[k] = AW'(2);
    tick(k);
    s_rd_valid[k] = 1'b0;
    drain(k);
    chk("t5_new_read", n_out, 1);
  endtask

  initial begin
    rst = '0;
    s_wr_valid = '0; s_rd_valid = '0; m_rd_ready = '0;
    s_wr_addr = '0; s_rd_addr = '0; s_wr_data = '0;
    #1 rst = '1;
    for (int k = 0; k < N; k++) begin
      reset_inst(k);
      test1(k);
      test2(k);
      test3(k);
      test4(k);
      test5(k);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
